key_cmd_debounce: RTL and testbench

- Upstream input-conditioning stage for the memory-command state machine.
- Takes four raw, asynchronous, active-low push-button inputs and synchronises each one into sys_clk.
- Debounces each key by requiring a stable level for DEBOUNCE_CYCLES clocks.
- Produces clean per-key outputs: one-cycle press/release pulses, a debounced level and a per-press toggle. The command FSM consumes these in place of asynchronous key edges.

---
 rtl/key_cmd_debounce.sv | 131 +++++++++++++
 tb/tb_key_cmd_debounce.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_debounce.sv
// Four-channel push-button conditioner: 2-flop synchroniser per key, then an
// independent debounce FSM per key producing press/release pulses, level and toggle.
module key_cmd_debounce #(
    parameter int N_KEYS          = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_toggle
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_KEYS-1:0] key_s_p0;
    logic [N_KEYS-1:0] key_s_p1;

    // Synchroniser stage: idles high (released) so reset never looks like a press
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            key_s_p0 <= '1;
            key_s_p1 <= '1;
        end else begin
            key_s_p0 <= key_n;
            key_s_p1 <= key_s_p0;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             press_q, press_nxt;
        logic             release_q, release_nxt;
        logic             level_q, level_nxt;
        logic             toggle_q, toggle_nxt;
        logic             s;

        assign s = key_s_p1[i];

        // Debounce stage: state, counter and all outputs are registered together
        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                state     <= RELEASED;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                level_q   <= 1'b0;
                toggle_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                level_q   <= level_nxt;
                toggle_q  <= toggle_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            level_nxt   = level_q;
            toggle_nxt  = toggle_q;
            case (state)
                RELEASED: begin
                    if (!s) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt  = PRESSED;
                        cnt_nxt    = '0;
                        press_nxt  = 1'b1;
                        level_nxt  = 1'b1;
                        toggle_nxt = ~toggle_q;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (s) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = RELEASED;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_level[i]   = level_q;
        assign key_toggle[i]  = toggle_q;
    end

endmodule

// File: tb/tb_key_cmd_debounce.sv
// Bench for key_cmd_debounce: constant table for a clean press/release, directed
// corner-case sequences, then random key activity against a run-length model.
module tb_key_cmd_debounce;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int CW  = 3;

    logic         sys_clk = 1'b0;
    logic         rst     = 1'b1;
    logic [N-1:0] key_n   = '1;
    logic [N-1:0] key_press, key_release, key_level, key_toggle;

    key_cmd_debounce #(.N_KEYS(N), .CNT_W(CW), .DEBOUNCE_CYCLES(DEB)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_press  (key_press),
        .key_release(key_release),
        .key_level  (key_level),
        .key_toggle (key_toggle)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: a key's debounced level flips once the synchronised input has
    // disagreed with it for DEB+1 consecutive samples.
    logic [N-1:0] m_s1, m_s2, m_level, m_toggle, m_press, m_rel;
    int           m_run [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] kn, input logic r);
        logic [N-1:0] s;
        logic         act;
        if (r) begin
            m_s1 = '1; m_s2 = '1;
            m_level = '0; m_toggle = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = kn;
            for (int i = 0; i < N; i++) begin
                act        = ~s[i];
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (act != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_level[i] = act;
                        m_run[i]   = 0;
                        if (act) begin
                            m_press[i]  = 1'b1;
                            m_toggle[i] = ~m_toggle[i];
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] kn, input logic r);
        @(negedge sys_clk);
        key_n = kn;
        rst   = r;
        @(posedge sys_clk);
        #1;
        model_edge(kn, r);
        check("model", {key_press, key_release, key_level, key_toggle},
              {m_press, m_rel, m_level, m_toggle});
    endtask

    task automatic do_reset();
        step('1, 1'b1);
        step('1, 1'b1);
    endtask

    typedef struct {
        logic [N-1:0] kn;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] level;
        logic [N-1:0] toggle;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int np, nr, idx;
        logic [N-1:0] kn;

        for (int j = 0; j < 20; j++) begin
            tbl[j].kn     = (j < 10) ? 4'b1110 : 4'b1111;
            tbl[j].press  = (j == 6)  ? 4'b0001 : 4'b0000;
            tbl[j].rel    = (j == 16) ? 4'b0001 : 4'b0000;
            tbl[j].level  = (j >= 6 && j < 16) ? 4'b0001 : 4'b0000;
            tbl[j].toggle = (j >= 6) ? 4'b0001 : 4'b0000;
        end

        model_edge('1, 1'b1);
        do_reset();
        check("reset_outputs", {key_press, key_release, key_level, key_toggle}, 0);

        // Clean press then release on key 0
        for (int j = 0; j < 20; j++) begin
            step(tbl[j].kn, 1'b0);
            check("tbl_press",  key_press,   tbl[j].press);
            check("tbl_rel",    key_release, tbl[j].rel);
            check("tbl_level",  key_level,   tbl[j].level);
            check("tbl_toggle", key_toggle,  tbl[j].toggle);
        end

        // Bounce on key 1: low 3, high 1, low 10
        np = 0; idx = -1;
        for (int j = 0; j < 14; j++) begin
            step((j == 3) ? 4'b1111 : 4'b1101, 1'b0);
            if (key_press[1]) begin np++; idx = j; end
        end
        check("bounce_count", np, 1);
        check("bounce_index", idx, 10);
        for (int j = 0; j < 8; j++) step('1, 1'b0);

        // Simultaneous press on keys 2 and 3
        do_reset();
        np = 0; idx = -1;
        for (int j = 0; j < 10; j++) begin
            step(4'b0011, 1'b0);
            if (key_press != 0) begin np++; idx = j; check("simul_pair", key_press, 4'b1100); end
        end
        check("simul_events", np, 1);
        check("simul_index", idx, 6);
        check("simul_toggle", key_toggle, 4'b1100);
        for (int j = 0; j < 8; j++) step('1, 1'b0);

        // Reset while key 0 is mid-qualification
        do_reset();
        np = 0;
        for (int j = 0; j < 5; j++) begin
            step(4'b1110, 1'b0);
            if (key_press[0]) np++;
        end
        step(4'b1110, 1'b1);
        step(4'b1110, 1'b1);
        check("midrst_outputs", {key_press, key_release, key_level, key_toggle}, 0);
        idx = -1;
        for (int j = 0; j < 10; j++) begin
            step(4'b1110, 1'b0);
            if (key_press[0]) begin np++; idx = j; end
        end
        check("midrst_count", np, 1);
        check("midrst_index", idx, 6);
        for (int j = 0; j < 8; j++) step('1, 1'b0);

        // Five press/release cycles on key 1
        do_reset();
        np = 0; nr = 0;
        for (int c = 0; c < 5; c++) begin
            for (int j = 0; j < 16; j++) begin
                step((j < 8) ? 4'b1101 : 4'b1111, 1'b0);
                if (key_press[1])   np++;
                if (key_release[1]) nr++;
            end
        end
        check("toggle_presses",  np, 5);
        check("toggle_releases", nr, 5);
        check("toggle_final",    key_toggle[1], 1);

        // Random bouncing keys with occasional reset
        kn = '1;
        for (int j = 0; j < 3000; j++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) kn[i] = ~kn[i];
            step(kn, ($urandom_range(399) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
